// File: rtl/deglitch_pkg.sv
// Shared constants and helpers for filtered-input blocks.
// Used by the deglitcher bank and other debounce-style front ends.
package deglitch_pkg;

    localparam int DG_SYNC_STAGES_DEF = 2;
    localparam int DG_CNT_W_DEF       = 4;

    // A programmed threshold of zero behaves like one.
    function automatic int unsigned eff_thresh(input int unsigned t);
        return (t == 0) ? 1 : t;
    endfunction

endpackage

// File: rtl/deglitch_ch.sv
// One deglitcher channel: synchroniser, run counter, commit and
// rise/fall strobe registers.
module deglitch_ch
    import deglitch_pkg::*;
#(
    parameter int   CNT_W       = DG_CNT_W_DEF,
    parameter int   SYNC_STAGES = DG_SYNC_STAGES_DEF,
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic             clk_16M,
    input  logic             rst,
    input  logic [CNT_W-1:0] thresh,
    input  logic             din,
    output logic             dout,
    output logic             rise,
    output logic             fall,
    output logic             busy
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   dat_q;
    logic                   rise_q;
    logic                   fall_q;
    logic                   busy_q;

    logic                   s;
    logic                   differ;
    logic [CNT_W:0]         cnt_inc;
    logic [CNT_W:0]         neff;
    logic                   commit;

    assign s = sync_q[SYNC_STAGES-1];

    // Compare one bit wider than the counter so the last step never wraps.
    always_comb begin
        differ  = (s != dat_q);
        cnt_inc = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
        neff    = (CNT_W+1)'(eff_thresh(32'(thresh)));
        commit  = differ && (cnt_inc >= neff);
    end

    always_ff @(posedge clk_16M) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{RESET_LEVEL}};
            cnt_q  <= '0;
            dat_q  <= RESET_LEVEL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            rise_q <= commit & s;
            fall_q <= commit & ~s;
            if (commit) begin
                dat_q  <= s;
                cnt_q  <= '0;
                busy_q <= 1'b0;
            end else if (differ) begin
                cnt_q  <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                busy_q <= 1'b1;
            end else begin
                cnt_q  <= '0;
                busy_q <= 1'b0;
            end
        end
    end

    assign dout = dat_q;
    assign rise = rise_q;
    assign fall = fall_q;
    assign busy = busy_q;

endmodule

// File: rtl/deglitch_bank.sv
// Multi-channel input deglitcher with programmable agreement count
// and single-cycle rise/fall strobes.
module deglitch_bank
    import deglitch_pkg::*;
#(
    parameter int   CH          = 4,
    parameter int   CNT_W       = DG_CNT_W_DEF,
    parameter int   SYNC_STAGES = DG_SYNC_STAGES_DEF,
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic             clk_16M,
    input  logic             rst,
    input  logic [CNT_W-1:0] thresh,
    input  logic [CH-1:0]    dat_i,
    output logic [CH-1:0]    dat_o,
    output logic [CH-1:0]    rise_o,
    output logic [CH-1:0]    fall_o,
    output logic [CH-1:0]    busy_o
);

    for (genvar g = 0; g < CH; g++) begin : g_ch
        deglitch_ch #(
            .CNT_W       (CNT_W),
            .SYNC_STAGES (SYNC_STAGES),
            .RESET_LEVEL (RESET_LEVEL)
        ) u_ch (
            .clk_16M (clk_16M),
            .rst     (rst),
            .thresh  (thresh),
            .din     (dat_i[g]),
            .dout    (dat_o[g]),
            .rise    (rise_o[g]),
            .fall    (fall_o[g]),
            .busy    (busy_o[g])
        );
    end

endmodule

// File: doc/deglitch_bank.md
# deglitch_bank

Multi-channel, parametrised input deglitcher for slow digital inputs (keys, comparator outputs, frame-sync lines) in the 16 MHz receive domain. Each channel synchronises its asynchronous input, and commits a new level only after a run-time-programmable number of consecutive agreeing samples. It also emits single-cycle rise/fall strobes. It replaces the fixed single-bit, fixed-threshold deglitcher for all new input paths.

## Interface
Parameters:
- CH, 4, number of independent channels (≥1)
- CNT_W, 4, width of threshold and per-channel run counter (≥1)
- SYNC_STAGES, 2, flops in each input synchroniser (≥2)
- RESET_LEVEL, 1'b0, level loaded into synchronisers and dat_o on reset

Ports:
- clk_16M  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- thresh  in  CNT_W  required consecutive differing samples N; 0 treated as 1
- dat_i  in  CH  raw asynchronous inputs
- dat_o  out  CH  filtered levels, registered
- rise_o  out  CH  one-cycle strobe, dat_o bit went 0→1
- fall_o  out  CH  one-cycle strobe, dat_o bit went 1→0
- busy_o  out  CH  registered; high while a channel's run counter is non-zero

## Operation
- Per channel: s = last synchroniser stage. Compare s with the channel's dat_o each cycle.
- s == dat_o: counter ← 0 (any partial run discarded; one bounce restarts the count).
- s != dat_o and counter+1 ≥ Neff (Neff = max(thresh,1)):
  - dat_o ← s, counter ← 0
  - rise_o or fall_o ← 1 for exactly one cycle, per direction.
- s != dat_o otherwise: counter ← counter+1.
- Comparison counter+1 ≥ Neff is done at CNT_W+1 bits; the counter never exceeds 2^CNT_W−2, so it never wraps.
- thresh is sampled every cycle, unregistered. Lowering it mid-run commits on the next differing sample if counter+1 ≥ new Neff. Raising it extends the current run.
- Channels are fully independent. Simultaneous commits on several channels all strobe in the same cycle.
- Reset:
  - synchronisers and dat_o ← RESET_LEVEL
  - counters ← 0
  - rise_o/fall_o/busy_o ← 0
- Reset mid-run discards the run. No strobe is generated by reset itself.
- First cycle after reset release: if inputs differ from RESET_LEVEL, a normal run starts. A strobe occurs only after SYNC_STAGES+Neff sampling edges.

## Timing
- Latency: dat_o changes on the (SYNC_STAGES+Neff)-th rising edge at which dat_i is sampled at the new level. Count the first sampling edge as 1. Default N=3: edge 5.
- rise_o/fall_o assert in the same cycle dat_o changes, and deassert the next cycle.
- busy_o is high from the edge after the first differing sample until the commit or abort edge.
- Minimum pulse at dat_i that can propagate: Neff cycles. Shorter pulses never change dat_o.
- Throughput: a new commit is possible every Neff cycles after the previous one, per channel.
- No handshake; outputs are level/strobe only.

## Structure
- Sub-module deglitch_ch: one channel (synchroniser, counter, compare, strobe regs), generated CH times by deglitch_bank.
- Shared package deglitch_pkg:
  - default constants DG_SYNC_STAGES_DEF=2, DG_CNT_W_DEF=4
  - function eff_thresh (0→1 mapping), reused by other filtered-input blocks
- No other shared types.

## Test plan
- Reset/idle: rst high 3 cycles, RESET_LEVEL=0, dat_i=0 → dat_o=0, strobes 0, busy_o=0 throughout.
- Clean edge: thresh=3, SYNC_STAGES=2, channel 0 steps 0→1 and holds. Required:
  - dat_o[0]=1 on 5th sampling edge
  - rise_o[0] one cycle only
  - other channels unchanged
- Glitch reject: thresh=3, dat_i[1] high for 2 cycles, low, then high for 2 cycles → dat_o[1] stays 0, busy_o[1] pulses, no strobe.
- Threshold edge cases:
  - thresh=0 behaves as 1: dat_o follows after SYNC_STAGES+1 edges
  - thresh=15: change needs exactly 15 consecutive samples; counter reaches 14 without wrap
  - thresh lowered 15→2 while counter=5 → commit on next differing sample
- Simultaneous/mixed: ch0 rises while ch3 falls with equal timing, thresh=3 → rise_o[0] and fall_o[3] in the same cycle.
- Reset mid-run: assert rst while counter=2 → counter 0, dat_o=RESET_LEVEL. After release, a full SYNC_STAGES+Neff run is required before any strobe.
